bsg_two_buf: RTL and testbench
==============================

# bsg_two_buf

Registered, two-entry valid/ready buffer for `width_p`-bit words. It is the sequential counterpart of the pass-through buffer: it sits at the receiving end of a link, breaks the timing path, and absorbs one cycle of consumer back-pressure. Both `ready_o` and `v_o` come straight from flops, so no combinational path crosses the block. Full throughput is one word per cycle.

## Interface
- `width_p`, default 64: data word width in bits; minimum 1.

- `clk_i`, input, 1: sole clock; all flops are rising-edge.
- `reset_n_i`, input, 1: reset, asynchronous assert, active-low.
- `v_i`, input, 1: producer has a valid word on `data_i`.
- `data_i`, input, `width_p`: producer word.
- `ready_o`, output, 1: buffer accepts a word this cycle. Registered.
- `v_o`, output, 1: `data_o` holds a valid word. Registered.
- `data_o`, output, `width_p`: head-of-buffer word. Driven directly from a storage register.
- `yumi_i`, input, 1: consumer takes the head word this cycle. Legal only when `v_o`=1.

## Operation
- Storage:
  - two `width_p` registers, `mem[0]` and `mem[1]`;
  - 1-bit `wr_ptr` and `rd_ptr`;
  - state EMPTY, ONE or FULL (equivalently a 2-bit count 0..2).
- Enqueue (`enq`) = `v_i & ready_o`. On `enq`, `mem[wr_ptr]` <= `data_i` and `wr_ptr` toggles.
- Dequeue (`deq`) = `yumi_i & v_o`. On `deq`, `rd_ptr` toggles.
- `data_o` = `mem[rd_ptr]`.
- `ready_o` = (state != FULL). `v_o` = (state != EMPTY). Both are decoded from registered state only.
- Transitions (enq, deq):
  - EMPTY: (1,x) -> ONE; otherwise stay. `deq` cannot occur.
  - ONE: (1,0) -> FULL; (0,1) -> EMPTY; (1,1) -> ONE; (0,0) -> ONE.
  - FULL: deq -> ONE; otherwise stay. `enq` cannot occur.
- Pointers wrap 1 -> 0 naturally. Word order is strictly FIFO; no word is dropped or duplicated.
- `v_i` with `ready_o`=0: no state change. The producer must hold `v_i`/`data_i` until accepted.
- `yumi_i` with `v_o`=0: protocol violation.
  - RTL ignores it; state does not change.
  - A simulation-only assertion fires at the clock edge, with reset deasserted.
- `v_i` may be asserted before the producer sees `ready_o`. Acceptance is decided purely by `ready_o` on that edge.

## Timing
- Reset: while `reset_n_i`=0, the following hold immediately, independent of clock:
  - state EMPTY;
  - `wr_ptr`=0, `rd_ptr`=0;
  - `mem[0]`=`mem[1]`=0;
  - `v_o`=0, `data_o`=0;
  - `ready_o`=0, forced low during reset.
- First rising edge after deassertion: `ready_o`=1. Deassertion is synchronised externally.
- Reset mid-operation: all held words are discarded. Outputs go to reset values asynchronously.
- Latency: a word accepted at edge N appears on `data_o` with `v_o`=1 immediately after edge N (one cycle), provided the buffer was EMPTY.
- Throughput: with continuous `v_i` and `yumi_i`, state stays ONE and one word moves per cycle.
- Back-pressure:
  - consumer stalls 1 cycle: state ONE -> FULL, and `ready_o` drops after the edge;
  - consumer resumes: FULL -> ONE, and `ready_o` rises after the next edge.
- In FULL, simultaneous `v_i` and `yumi_i`: only the dequeue happens, since `ready_o`=0. Next state ONE.
- No combinational path from any input to any output.

## Test plan
- Reset:
  - Stimulus: assert `reset_n_i`=0 mid-cycle with the buffer FULL.
  - Required: `v_o`, `ready_o`, `data_o` go to 0 without a clock edge.
  - After release, first edge gives `ready_o`=1 and `v_o`=0.
- Single word:
  - Stimulus: enqueue 0xDEADBEEF_CAFEF00D at edge 1; `yumi_i`=0 for 3 cycles, then 1.
  - Required: `v_o`=1 from edge 1 with a stable `data_o`; state EMPTY after the yumi edge.
- Streaming:
  - Stimulus: 100 consecutive words 0..99 with `yumi_i` held 1.
  - Required: one word out per cycle, in order, with `ready_o` never dropping.
- Fill and drain:
  - Stimulus: enqueue 0xA then 0xB with `yumi_i`=0.
  - Required: `ready_o`=0 after the second edge. A third `v_i` with value 0xC is not accepted until a yumi.
  - Output order 0xA, 0xB, 0xC; no loss.
- FULL with simultaneous `v_i`/`yumi_i`:
  - Required: one dequeue and no enqueue; state ONE; the held `v_i` word is accepted on the following edge.
- Illegal yumi:
  - Stimulus: `yumi_i`=1 while EMPTY.
  - Required: the assertion fires; `wr_ptr`/`rd_ptr`/state are unchanged; the subsequent enqueue behaves normally.
- Random:
  - Stimulus: random `v_i`/`yumi_i` over 10k cycles (yumi only when `v_o`).
  - Required: output matches a scoreboard FIFO exactly.

Source files
------------

// File: rtl/bsg_two_buf.sv
// bsg_two_buf: registered two-entry valid/ready buffer.
// Sits at the receiving end of a link to break the timing path and absorb
// one cycle of consumer back-pressure. ready_o and v_o come straight from
// flops, and data_o is selected from the storage registers by a registered
// pointer, so no input reaches any output combinationally.
module bsg_two_buf #(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e             state_r;
    state_e             state_n;
    logic [width_p-1:0] mem_r [2];
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic               ready_r;
    logic               v_r;
    logic               enq;
    logic               deq;

    // Handshakes are qualified by our own registered flags, so a yumi_i while
    // empty or a v_i while full has no effect on state.
    assign enq = v_i & ready_r;
    assign deq = yumi_i & v_r;

    // Next-state decode from the current occupancy and this cycle's handshakes.
    always_comb begin
        // NOTE: default assigned first so every path drives state_n; no latch.
        state_n = state_r;
        unique case (state_r)
            EMPTY: if (enq) state_n = ONE;
            ONE: begin
                if (enq && !deq)      state_n = FULL;
                else if (!enq && deq) state_n = EMPTY;
            end
            FULL: if (deq) state_n = ONE;
            default: state_n = EMPTY;
        endcase
    end

    // State, pointers and the registered output flags.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            // NOTE: sequential state uses non-blocking assignment throughout.
            state_r  <= EMPTY;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            // ready_r is held low in reset and rises on the first edge after it.
            ready_r  <= 1'b0;
            v_r      <= 1'b0;
        end else begin
            state_r <= state_n;
            ready_r <= (state_n != FULL);
            v_r     <= (state_n != EMPTY);
            if (enq) wr_ptr_r <= ~wr_ptr_r;
            if (deq) rd_ptr_r <= ~rd_ptr_r;
        end
    end

    // Word storage; written at the write pointer on every accepted word.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            // NOTE: storage is cleared on reset so data_o reads 0 while in reset;
            // only two words, so the reset cost is small.
            mem_r[0] <= '0;
            mem_r[1] <= '0;
        end else if (enq) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    assign ready_o = ready_r;
    assign v_o     = v_r;
    assign data_o  = mem_r[rd_ptr_r];

    // Simulation-only protocol monitor: the consumer must not yumi an empty buffer.
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(yumi_i && !v_r))
            else $warning("bsg_two_buf: yumi_i asserted while v_o is low (ignored)");
        end
    end

endmodule

// File: tb/tb_bsg_two_buf.sv
// Directed and random self-checking bench for bsg_two_buf.
module tb_bsg_two_buf;

    localparam int W = 64;

    logic         clk;
    logic         reset_n;
    logic         v_in;
    logic [W-1:0] data_in;
    logic         ready;
    logic         v_out;
    logic [W-1:0] data_out;
    logic         yumi;

    int passed = 0;
    int total  = 0;

    bsg_two_buf #(.width_p(W)) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .v_i      (v_in),
        .data_i   (data_in),
        .ready_o  (ready),
        .v_o      (v_out),
        .data_o   (data_out),
        .yumi_i   (yumi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard for the random phase.
    logic [W-1:0] sb_q[$];
    logic         pending;
    logic         enq_m;
    logic         deq_m;

    initial begin
        reset_n = 1'b0;
        v_in    = 1'b0;
        data_in = '0;
        yumi    = 1'b0;

        // ---- Reset state, then release mid-cycle ----
        #3;
        check("rst_v",     W'(v_out), W'(0));
        check("rst_ready", W'(ready), W'(0));
        check("rst_data",  data_out,  '0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", W'(ready), W'(1));
        check("post_rst_v",     W'(v_out), W'(0));

        // ---- Single word held for three cycles, then taken ----
        v_in = 1'b1; data_in = 64'hDEADBEEF_CAFEF00D;
        tick();
        v_in = 1'b0; data_in = '0;
        check("single_v",     W'(v_out), W'(1));
        check("single_data",  data_out,  64'hDEADBEEF_CAFEF00D);
        check("single_ready", W'(ready), W'(1));
        tick();
        tick();
        check("single_hold_v",    W'(v_out), W'(1));
        check("single_hold_data", data_out,  64'hDEADBEEF_CAFEF00D);
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        check("single_empty_v",     W'(v_out), W'(0));
        check("single_empty_ready", W'(ready), W'(1));

        // ---- Streaming 0..99 with yumi held ----
        v_in = 1'b1; data_in = 64'd0;
        tick();
        check("stream_first", data_out, 64'd0);
        for (int i = 1; i < 100; i++) begin
            data_in = W'(i);
            yumi    = 1'b1;
            tick();
            check("stream_data",  data_out,  W'(i));
            check("stream_ready", W'(ready), W'(1));
            check("stream_v",     W'(v_out), W'(1));
        end
        v_in = 1'b0;
        tick();
        yumi = 1'b0;
        check("stream_drained", W'(v_out), W'(0));

        // ---- Fill and drain, including FULL with simultaneous v_i/yumi_i ----
        v_in = 1'b1; data_in = 64'hA;
        tick();
        check("fill_a_data",  data_out,  64'hA);
        check("fill_a_ready", W'(ready), W'(1));
        data_in = 64'hB;
        tick();
        check("fill_full_ready", W'(ready), W'(0));
        check("fill_full_head",  data_out,  64'hA);
        data_in = 64'hC;
        tick();
        check("fill_c_blocked_ready", W'(ready), W'(0));
        check("fill_c_blocked_head",  data_out,  64'hA);
        yumi = 1'b1;                       // FULL with v_i and yumi_i both high
        tick();
        check("full_both_head",  data_out,  64'hB);
        check("full_both_ready", W'(ready), W'(1));
        check("full_both_v",     W'(v_out), W'(1));
        yumi = 1'b0;                       // held C is accepted on this edge
        tick();
        v_in = 1'b0;
        check("c_accept_ready", W'(ready), W'(0));
        check("c_accept_head",  data_out,  64'hB);
        yumi = 1'b1;
        tick();
        check("drain_c", data_out, 64'hC);
        tick();
        yumi = 1'b0;
        check("drain_empty_v", W'(v_out), W'(0));

        // ---- Illegal yumi while empty: ignored ----
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        check("illegal_v",     W'(v_out), W'(0));
        check("illegal_ready", W'(ready), W'(1));
        v_in = 1'b1; data_in = 64'h55;
        tick();
        v_in = 1'b0;
        check("after_illegal_data", data_out,  64'h55);
        check("after_illegal_v",    W'(v_out), W'(1));
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
        check("after_illegal_empty", W'(v_out), W'(0));

        // ---- Asynchronous reset mid-cycle with the buffer FULL ----
        v_in = 1'b1; data_in = 64'h1111;
        tick();
        data_in = 64'h2222;
        tick();
        v_in = 1'b0;
        check("pre_reset_full", W'(ready), W'(0));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_v",     W'(v_out), W'(0));
        check("async_rst_ready", W'(ready), W'(0));
        check("async_rst_data",  data_out,  '0);
        tick();
        reset_n = 1'b1;
        tick();
        check("rerst_ready", W'(ready), W'(1));
        check("rerst_v",     W'(v_out), W'(0));

        // ---- Random traffic against a scoreboard ----
        pending = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!pending) begin
                v_in    = 1'($urandom_range(0, 1));
                data_in = {$urandom, $urandom};
            end
            yumi  = (sb_q.size() != 0) && ($urandom_range(0, 3) != 0);
            enq_m = v_in && (sb_q.size() != 2);
            deq_m = yumi;
            tick();
            if (deq_m) void'(sb_q.pop_front());
            if (enq_m) sb_q.push_back(data_in);
            pending = v_in && !enq_m;
            check("rnd_v",     W'(v_out), W'(sb_q.size() != 0));
            check("rnd_ready", W'(ready), W'(sb_q.size() != 2));
            if (sb_q.size() != 0) check("rnd_data", data_out, sb_q[0]);
        end
        v_in = 1'b0;
        yumi = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
